// File: rtl/core_pkg.sv
// Shared core definitions used by Decode, the Decode/Execute pipeline
// register and the execution units.
//   XLEN        : operand data width
//   REG_ADDR_W  : register index width
//   EXEC_TYPE_W : execute-type code width
//   exec_type_e : execute-type encoding carried from Decode to Execute
package core_pkg;

  localparam int XLEN        = 32;
  localparam int REG_ADDR_W  = 5;
  localparam int EXEC_TYPE_W = 5;

  typedef enum logic [EXEC_TYPE_W-1:0] {
    EXEC_ADD   = 5'd0,
    EXEC_SUB   = 5'd1,
    EXEC_SLL   = 5'd2,
    EXEC_SLT   = 5'd3,
    EXEC_SLTU  = 5'd4,
    EXEC_XOR   = 5'd5,
    EXEC_SRL   = 5'd6,
    EXEC_SRA   = 5'd7,
    EXEC_OR    = 5'd8,
    EXEC_AND   = 5'd9,
    EXEC_MUL   = 5'd10,
    EXEC_MULH  = 5'd11,
    EXEC_LOAD  = 5'd12,
    EXEC_STORE = 5'd13
  } exec_type_e;

  // True when no unit is selected and nothing is written back.
  function automatic logic is_bubble(input logic reg_write, input logic au,
                                     input logic mul, input logic lsu);
    return !(reg_write | au | mul | lsu);
  endfunction

endpackage

// File: rtl/transfer_decode_execute_pipe_reg_en.sv
// pipe_reg_en: WIDTH-bit register with asynchronous active-low clear and a
// load enable.
//   clk   : rising-edge clock
//   rst_n : async clear, active low (overrides en)
//   en    : 1 = load d on the edge, 0 = hold
//   d     : data in
//   q     : registered data out
module pipe_reg_en #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/transfer_decode_execute.sv
// transfer_decode_execute: Decode -> Execute pipeline register.
// Captures operands, rd, reg_write, execute type and unit-select flags every
// rising edge unless stalled. Reset clears everything, which is a NOP bubble.
//   clk, rst_n            : clock, async active-low reset
//   stall                 : 1 = hold outputs, ignore decode inputs
//   *_decode              : fields from Decode
//   *_execute             : registered fields to Execute
module transfer_decode_execute #(
  parameter int XLEN        = core_pkg::XLEN,
  parameter int REG_ADDR_W  = core_pkg::REG_ADDR_W,
  parameter int EXEC_TYPE_W = core_pkg::EXEC_TYPE_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   stall,
  input  logic [XLEN-1:0]        operand1_decode,
  input  logic [XLEN-1:0]        operand2_decode,
  input  logic                   reg_write_decode,
  input  logic [REG_ADDR_W-1:0]  rd_decode,
  input  logic [EXEC_TYPE_W-1:0] execute_type_decode,
  input  logic                   au_decode,
  input  logic                   mul_decode,
  input  logic                   lsu_decode,
  output logic [XLEN-1:0]        operand1_execute,
  output logic [XLEN-1:0]        operand2_execute,
  output logic                   reg_write_execute,
  output logic [REG_ADDR_W-1:0]  rd_execute,
  output logic [EXEC_TYPE_W-1:0] execute_type_execute,
  output logic                   au_execute,
  output logic                   mul_execute,
  output logic                   lsu_execute
);

  localparam int BW = 2*XLEN + 1 + REG_ADDR_W + EXEC_TYPE_W + 3;

  logic [BW-1:0] bundle_d;
  logic [BW-1:0] bundle_q;

  // One register on the whole bundle: every field shares enable and clear,
  // so the all-zero reset value is a bubble by construction.
  assign bundle_d = {operand1_decode, operand2_decode, reg_write_decode,
                     rd_decode, execute_type_decode,
                     au_decode, mul_decode, lsu_decode};

  pipe_reg_en #(.WIDTH(BW)) u_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (~stall),
    .d     (bundle_d),
    .q     (bundle_q)
  );

  assign {operand1_execute, operand2_execute, reg_write_execute,
          rd_execute, execute_type_execute,
          au_execute, mul_execute, lsu_execute} = bundle_q;

endmodule

// File: tb/tb_transfer_decode_execute.sv
module tb_transfer_decode_execute;
  import core_pkg::*;

  typedef struct packed {
    logic [31:0] op1;
    logic [31:0] op2;
    logic        rw;
    logic [4:0]  rd;
    logic [4:0]  et;
    logic        au;
    logic        mul;
    logic        lsu;
  } bundle_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic [31:0] op1_d, op2_d, op1_x, op2_x;
  logic        rw_d, rw_x, au_d, au_x, mul_d, mul_x, lsu_d, lsu_x;
  logic [4:0]  rd_d, rd_x, et_d, et_x;

  bundle_t obs;
  bundle_t model;
  bundle_t sb[$];
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  transfer_decode_execute dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .stall                (stall),
    .operand1_decode      (op1_d),
    .operand2_decode      (op2_d),
    .reg_write_decode     (rw_d),
    .rd_decode            (rd_d),
    .execute_type_decode  (et_d),
    .au_decode            (au_d),
    .mul_decode           (mul_d),
    .lsu_decode           (lsu_d),
    .operand1_execute     (op1_x),
    .operand2_execute     (op2_x),
    .reg_write_execute    (rw_x),
    .rd_execute           (rd_x),
    .execute_type_execute (et_x),
    .au_execute           (au_x),
    .mul_execute          (mul_x),
    .lsu_execute          (lsu_x)
  );

  assign obs = {op1_x, op2_x, rw_x, rd_x, et_x, au_x, mul_x, lsu_x};

  task automatic check(input string tag, input bundle_t o, input bundle_t e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic drive(input bundle_t b, input logic st);
    {op1_d, op2_d, rw_d, rd_d, et_d, au_d, mul_d, lsu_d} = b;
    stall = st;
  endtask

  // One clock: drive, confirm outputs did not move before the edge, push the
  // expected post-edge value, take the edge, pop and compare.
  task automatic cyc(input string tag, input bundle_t b, input logic st);
    bundle_t e;
    drive(b, st);
    #1;
    check({tag, "_pre"}, obs, model);
    sb.push_back(!rst_n ? bundle_t'('0) : (st ? model : b));
    @(posedge clk);
    #1;
    e = sb.pop_front();
    model = e;
    check(tag, obs, e);
  endtask

  function automatic bundle_t mk(input logic [31:0] a, input logic [31:0] b,
                                 input logic rw, input logic [4:0] rd,
                                 input logic [4:0] et, input logic [2:0] fl);
    return {a, b, rw, rd, et, fl};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bundle_t busy;
    busy  = mk(32'hCAFEF00D, 32'h0BADBEEF, 1'b1, 5'd7, 5'd12, 3'b111);
    model = '0;
    // Reset asserted at time 0 with busy inputs
    rst_n = 1'b0;
    drive(busy, 1'b0);
    #2;
    check("reset_immediate", obs, '0);
    cyc("reset_hold_1", busy, 1'b0);
    cyc("reset_hold_2", busy, 1'b0);
    // Release reset between edges; outputs stay 0 until next edge
    #2 rst_n = 1'b1;
    #1 check("reset_release_wait", obs, '0);
    cyc("first_load", busy, 1'b0);

    // Pulse reset mid-cycle while running: clears without an edge
    #2 rst_n = 1'b0;
    #1 check("reset_pulse", obs, '0);
    model = '0;
    cyc("reset_pulse_hold", busy, 1'b0);
    #1 rst_n = 1'b1;

    // Pass-through
    cyc("pass", mk(32'hDEADBEEF, 32'h00000123, 1'b1, 5'd10, EXEC_SLT, 3'b100), 1'b0);

    // Back-to-back
    for (int i = 1; i <= 6; i++)
      cyc("b2b", mk(i, 32'h100 + i, i[0], i[4:0], i[4:0], i[2:0]), 1'b0);

    // Stall hold
    cyc("stall_load", mk(32'hAAAA5555, 32'h1, 1'b1, 5'd3, EXEC_ADD, 3'b100), 1'b0);
    for (int i = 0; i < 3; i++)
      cyc("stall_hold", mk(32'h12345678, 32'h2, 1'b0, 5'd4, EXEC_MUL, 3'b010), 1'b1);
    cyc("stall_release", mk(32'h12345678, 32'h2, 1'b0, 5'd4, EXEC_MUL, 3'b010), 1'b0);

    // Reset during stall
    cyc("rd31_load", mk(32'h55, 32'h66, 1'b1, 5'd31, EXEC_LOAD, 3'b001), 1'b0);
    cyc("rd31_stall", busy, 1'b1);
    #2 rst_n = 1'b0;
    #1 check("reset_in_stall", obs, '0);
    model = '0;
    cyc("reset_in_stall_hold", busy, 1'b1);
    // Release with stall=1: first edge holds zeros, then stall drops
    #1 rst_n = 1'b1;
    cyc("release_stalled", busy, 1'b1);
    cyc("release_load", busy, 1'b0);

    // Flag independence at maximum field values
    cyc("flags_001", mk(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 5'd31, 5'd31, 3'b001), 1'b0);
    cyc("flags_010", mk(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 5'd31, 5'd31, 3'b010), 1'b0);
    cyc("flags_100", mk(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 5'd31, 5'd31, 3'b100), 1'b0);
    cyc("flags_111", mk(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 5'd31, 5'd31, 3'b111), 1'b0);
    cyc("bubble",    mk(32'h0, 32'h0, 1'b0, 5'd0, 5'd0, 3'b000), 1'b0);
    total++;
    assert (is_bubble(rw_x, au_x, mul_x, lsu_x)) else begin
      bad++;
      $error("FAIL bubble_flags observed=%b expected=1", is_bubble(rw_x, au_x, mul_x, lsu_x));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/transfer_decode_execute.md
# transfer_decode_execute

Pipeline register between the Decode and Execute stages of the superscalar RISC-V core. It captures the decoded operands, destination register, write-enable, execute-type code and functional-unit select flags on each rising clock edge and presents them to Execute one cycle later. A stall input freezes the register contents. Reset clears all outputs, producing a bubble: no register write and no unit selected.

## Interface
Parameters:
- XLEN, 32, operand data width
- REG_ADDR_W, 5, register-index width
- EXEC_TYPE_W, 5, execute-type code width

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- stall  in  1  1 = hold all outputs and ignore decode inputs
- operand1_decode  in  XLEN  first source operand value
- operand2_decode  in  XLEN  second source operand or immediate
- reg_write_decode  in  1  instruction writes rd
- rd_decode  in  REG_ADDR_W  destination register index
- execute_type_decode  in  EXEC_TYPE_W  operation code for the selected unit
- au_decode  in  1  route to arithmetic unit
- mul_decode  in  1  route to multiplier
- lsu_decode  in  1  route to load/store unit
- operand1_execute  out  XLEN  registered operand1
- operand2_execute  out  XLEN  registered operand2
- reg_write_execute  out  1  registered reg_write
- rd_execute  out  REG_ADDR_W  registered rd
- execute_type_execute  out  EXEC_TYPE_W  registered execute_type
- au_execute  out  1  registered au
- mul_execute  out  1  registered mul
- lsu_execute  out  1  registered lsu

## Operation
- Each *_execute output is driven directly by a flip-flop holding the matching *_decode input. No combinational path from any input to any output.
- Rising edge with rst_n=1 and stall=0: every output takes its *_decode value.
- Rising edge with rst_n=1 and stall=1: every output keeps its previous value, bit for bit.
- rst_n=0: every output goes to 0 immediately, without waiting for a clock edge, and stays 0 while rst_n is low. rst_n low overrides stall.
- The block passes fields through as-is. It does not check that at most one of au/mul/lsu is set, and does not test rd=0. Those rules belong to Decode and Execute.
- The all-zero state is a legal NOP bubble: reg_write=0, au=mul=lsu=0.

## Timing
- Latency: exactly 1 clock. A value applied at the decode inputs before edge N appears at the outputs just after edge N.
- Throughput: one instruction per cycle while stall=0.
- Stall is sampled at the rising edge. A stall asserted for k edges holds the outputs for k cycles. The first edge with stall=0 loads whatever the decode inputs hold at that edge.
- Reset deassertion: outputs stay 0 until the first rising edge after rst_n goes high. That edge loads the inputs if stall=0, or holds the zeros if stall=1.
- Reset asserted mid-stall or mid-stream: outputs clear at once. The held instruction is discarded.

## Structure
- Shared package (core_pkg): XLEN, REG_ADDR_W and EXEC_TYPE_W constants, plus the execute_type encoding enum used by Decode and the execution units.
- One natural sub-module: pipe_reg_en, a parameterised WIDTH register with asynchronous active-low clear and an enable input. transfer_decode_execute instantiates it once per field, or once on the concatenated bundle, with enable = ~stall.

## Test plan
- Reset: drive all inputs to non-zero values and pulse rst_n low between clock edges. All outputs must read 0 before the next edge, and must stay 0 with stall=0 until rst_n rises.
- Pass-through: set operand1=0xDEADBEEF, operand2=0x00000123, reg_write=1, rd=5'd10, execute_type=5'd3, au=1, mul=0, lsu=0, stall=0. After one edge the outputs must match exactly.
- Back-to-back: change the inputs every cycle (operand1 = 1, 2, 3, …). The outputs must follow one cycle behind with no lost or repeated values.
- Stall hold: load operand1=0xAAAA5555. Assert stall for 3 edges while changing the inputs to 0x12345678. Outputs must hold 0xAAAA5555. After stall drops, the next edge must give 0x12345678.
- Reset during stall: hold stall=1 with rd_execute=5'd31 and pull rst_n low. rd_execute and all other outputs must clear to 0 immediately.
- Flag independence: step au/mul/lsu through 001, 010, 100 and 111 with the maximum-width values 0xFFFFFFFF, rd=31 and execute_type=31. Every bit must propagate unchanged.
